// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_pkg;

    localparam int DEFAULT_DIM    = 4;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Flat element index of (r,c) in a row-major packed DIM x DIM matrix.
    function automatic int elem_idx(input int r, input int c, input int dim);
        return r * dim + c;
    endfunction

endpackage

// File: rtl/systolic_sched_skew_feed.sv
// One edge lane of the skewed operand stream: picks matrix element or zero for step t.
module skew_feed
    import systolic_pkg::*;
#(
    parameter int DIM      = DEFAULT_DIM,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int T_W      = 4,
    parameter int LANE     = 0,
    parameter bit COL_MODE = 1'b0
) (
    input  logic [T_W-1:0]            t_i,
    input  logic [DIM*DIM*DATA_W-1:0] mat_i,
    output logic [DATA_W-1:0]         elem_o
);

    int rel_s;

    // Rows take A[lane][t-lane], columns take B[t-lane][lane]; outside the window the lane is zero.
    always_comb begin
        rel_s  = int'(t_i) - LANE;
        elem_o = '0;
        if ((rel_s >= 0) && (rel_s < DIM)) begin
            if (COL_MODE) begin
                elem_o = mat_i[elem_idx(rel_s, LANE, DIM)*DATA_W +: DATA_W];
            end else begin
                elem_o = mat_i[elem_idx(LANE, rel_s, DIM)*DATA_W +: DATA_W];
            end
        end else begin
            elem_o = '0;
        end
    end

endmodule

// File: rtl/systolic_sched.sv
// Sequencer for a DIM x DIM systolic multiply array: clear, skewed feed, drain, done pulse.
module systolic_sched
    import systolic_pkg::*;
#(
    parameter int DIM    = DEFAULT_DIM,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [DIM*DIM*DATA_W-1:0] a_mat_i,
    input  logic [DIM*DIM*DATA_W-1:0] b_mat_i,
    output logic [DIM*DATA_W-1:0]     left_o,
    output logic [DIM*DATA_W-1:0]     up_o,
    output logic                      pe_clr_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int MAT_W  = DIM * DIM * DATA_W;
    localparam int EDGE_W = DIM * DATA_W;
    localparam int T_W    = $clog2(3 * DIM);
    localparam logic [T_W-1:0] T_ONE        = T_W'(1);
    localparam logic [T_W-1:0] T_FEED_LAST  = T_W'(2 * DIM - 2);
    localparam logic [T_W-1:0] T_DRAIN_LAST = T_W'(3 * DIM - 3);

    state_e              state_q, state_d;
    logic [T_W-1:0]      t_q, t_d;
    logic [MAT_W-1:0]    a_q, a_d;
    logic [MAT_W-1:0]    b_q, b_d;
    logic [EDGE_W-1:0]   left_q, left_d;
    logic [EDGE_W-1:0]   up_q, up_d;
    logic                clr_q, clr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [EDGE_W-1:0]   sel_left_s;
    logic [EDGE_W-1:0]   sel_up_s;

    // Lane selectors look at next-cycle t so the edge registers line up with the FEED state.
    for (genvar g = 0; g < DIM; g++) begin : g_lane
        skew_feed #(
            .DIM      (DIM),
            .DATA_W   (DATA_W),
            .T_W      (T_W),
            .LANE     (g),
            .COL_MODE (1'b0)
        ) u_row (
            .t_i    (t_d),
            .mat_i  (a_q),
            .elem_o (sel_left_s[g*DATA_W +: DATA_W])
        );

        skew_feed #(
            .DIM      (DIM),
            .DATA_W   (DATA_W),
            .T_W      (T_W),
            .LANE     (g),
            .COL_MODE (1'b1)
        ) u_col (
            .t_i    (t_d),
            .mat_i  (b_q),
            .elem_o (sel_up_s[g*DATA_W +: DATA_W])
        );
    end

    // Next-state, step counter and operand latch.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                t_d = '0;
                if (start_i) begin
                    state_d = CLEAR;
                    a_d     = a_mat_i;
                    b_d     = b_mat_i;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                state_d = FEED;
                t_d     = '0;
            end
            FEED: begin
                t_d = t_q + T_ONE;
                if (t_q == T_FEED_LAST) begin
                    state_d = DRAIN;
                end else begin
                    state_d = FEED;
                end
            end
            DRAIN: begin
                t_d = t_q + T_ONE;
                if (t_q == T_DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        left_d = '0;
        up_d   = '0;
        clr_d  = 1'b0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        case (state_d)
            CLEAR: begin
                clr_d = 1'b1;
            end
            FEED: begin
                left_d = sel_left_s;
                up_d   = sel_up_s;
            end
            default: begin
                left_d = '0;
                up_d   = '0;
            end
        endcase
    end

    // State and output registers; reset also drops any latched operands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            t_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            left_q  <= '0;
            up_q    <= '0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            a_q     <= a_d;
            b_q     <= b_d;
            left_q  <= left_d;
            up_q    <= up_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign left_o   = left_q;
    assign up_o     = up_q;
    assign pe_clr_o = clr_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_systolic_sched.sv
// Self-checking bench: DIM=2 and DIM=4 sequencers driving a behavioural PE array model.
module tb_systolic_sched;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start2, start4;
    logic [2*2*DW-1:0] a2, b2;
    logic [2*DW-1:0]   left2, up2;
    logic              clr2, busy2, done2;
    logic [4*4*DW-1:0] a4, b4;
    logic [4*DW-1:0]   left4, up4;
    logic              clr4, busy4, done4;

    systolic_sched #(.DIM(2), .DATA_W(DW)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .a_mat_i(a2), .b_mat_i(b2),
        .left_o(left2), .up_o(up2), .pe_clr_o(clr2), .busy_o(busy2), .done_o(done2)
    );

    systolic_sched #(.DIM(4), .DATA_W(DW)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .a_mat_i(a4), .b_mat_i(b4),
        .left_o(left4), .up_o(up4), .pe_clr_o(clr4), .busy_o(busy4), .done_o(done4)
    );

    int cur_dim;
    logic [DW-1:0] obs_left[4];
    logic [DW-1:0] obs_up[4];
    logic obs_clr, obs_busy, obs_done;

    // Route whichever DUT is under test onto a common observation bus.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            obs_left[i] = '0;
            obs_up[i]   = '0;
        end
        obs_clr  = 1'b0;
        obs_busy = 1'b0;
        obs_done = 1'b0;
        if (cur_dim == 2) begin
            for (int i = 0; i < 2; i++) begin
                obs_left[i] = left2[i*DW +: DW];
                obs_up[i]   = up2[i*DW +: DW];
            end
            obs_clr  = clr2;
            obs_busy = busy2;
            obs_done = done2;
        end else begin
            for (int i = 0; i < 4; i++) begin
                obs_left[i] = left4[i*DW +: DW];
                obs_up[i]   = up4[i*DW +: DW];
            end
            obs_clr  = clr4;
            obs_busy = busy4;
            obs_done = done4;
        end
    end

    // Behavioural PE array: registered right/down hops, accumulate left*up each edge.
    logic [DW-1:0] pr[4][4];
    logic [DW-1:0] pd[4][4];
    logic [63:0]   pres[4][4];
    logic [DW-1:0] pe_lin[4][4];
    logic [DW-1:0] pe_uin[4][4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pe_lin[i][j] = (j == 0) ? obs_left[i] : pr[i][(j == 0) ? 0 : j-1];
                pe_uin[i][j] = (i == 0) ? obs_up[j]   : pd[(i == 0) ? 0 : i-1][j];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (rst) begin
                    pr[i][j]   <= '0;
                    pd[i][j]   <= '0;
                    pres[i][j] <= '0;
                end else begin
                    pr[i][j]   <= pe_lin[i][j];
                    pd[i][j]   <= pe_uin[i][j];
                    pres[i][j] <= obs_clr ? 64'd0
                                : pres[i][j] + 64'(pe_lin[i][j]) * 64'(pe_uin[i][j]);
                end
            end
        end
    end

    int unsigned ma[4][4];
    int unsigned mb[4][4];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge operand expected m edges after the start edge, straight from the skew rule.
    function automatic logic [DW-1:0] exp_edge(input int dim, input int m, input int lane, input bit col);
        int t;
        int k;
        if (m < 1 || m > 2*dim-1) return '0;
        t = m - 1;
        k = t - lane;
        if (k < 0 || k >= dim) return '0;
        return col ? mb[k][lane] : ma[lane][k];
    endfunction

    task automatic check_step(input int dim, input int m);
        for (int l = 0; l < dim; l++) begin
            chk($sformatf("left%0d_d%0d_m%0d", l, dim, m), obs_left[l], exp_edge(dim, m, l, 1'b0));
            chk($sformatf("up%0d_d%0d_m%0d", l, dim, m), obs_up[l], exp_edge(dim, m, l, 1'b1));
        end
        chk($sformatf("clr_d%0d_m%0d", dim, m), obs_clr, (m == 0));
        chk($sformatf("busy_d%0d_m%0d", dim, m), obs_busy, (m <= 3*dim-1));
        chk($sformatf("done_d%0d_m%0d", dim, m), obs_done, (m == 3*dim-1));
    endtask

    task automatic check_res(input int dim);
        logic [63:0] s;
        for (int i = 0; i < dim; i++) begin
            for (int j = 0; j < dim; j++) begin
                s = 64'd0;
                for (int k = 0; k < dim; k++) s += 64'(ma[i][k]) * 64'(mb[k][j]);
                chk($sformatf("res_d%0d_%0d%0d", dim, i, j), pres[i][j], s);
            end
        end
    endtask

    task automatic load_inputs(input int dim);
        for (int r = 0; r < dim; r++) begin
            for (int c = 0; c < dim; c++) begin
                if (dim == 2) begin
                    a2[(r*2+c)*DW +: DW] = ma[r][c];
                    b2[(r*2+c)*DW +: DW] = mb[r][c];
                end else begin
                    a4[(r*4+c)*DW +: DW] = ma[r][c];
                    b4[(r*4+c)*DW +: DW] = mb[r][c];
                end
            end
        end
    endtask

    task automatic rand_mats(input int dim, input bit wide);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = (r < dim && c < dim) ? (wide ? $urandom : $urandom_range(0, 255)) : 0;
                mb[r][c] = (r < dim && c < dim) ? (wide ? $urandom : $urandom_range(0, 255)) : 0;
            end
        end
    endtask

    // One run from the start edge; optional held start, input scramble, or reset at step abort_m.
    task automatic run(input int dim, input bit hold, input bit mutate, input int abort_m);
        cur_dim = dim;
        load_inputs(dim);
        if (dim == 2) start2 = 1'b1; else start4 = 1'b1;
        tick();
        check_step(dim, 0);
        if (!hold) begin
            if (dim == 2) start2 = 1'b0; else start4 = 1'b0;
        end
        if (mutate) begin
            for (int k = 0; k < 4; k++) begin
                a2[k*DW +: DW] = $urandom;
                b2[k*DW +: DW] = $urandom;
            end
            for (int k = 0; k < 16; k++) begin
                a4[k*DW +: DW] = $urandom;
                b4[k*DW +: DW] = $urandom;
            end
        end
        for (int m = 1; m <= 3*dim; m++) begin
            tick();
            check_step(dim, m);
            if (m == 3*dim-1) check_res(dim);
            if (m == abort_m) begin
                rst = 1'b1;
                tick();
                check_step(dim, 3*dim);
                rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start2 = 1'b0;
        start4 = 1'b0;
        a2 = '0; b2 = '0; a4 = '0; b4 = '0;
        cur_dim = 2;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin ma[r][c] = 0; mb[r][c] = 0; end
        tick();
        tick();
        check_step(2, 6);
        cur_dim = 4;
        #1;
        check_step(4, 12);

        // Reset and start together: reset wins.
        start4 = 1'b1;
        tick();
        check_step(4, 12);
        rst = 1'b0;
        start4 = 1'b0;
        tick();
        check_step(4, 12);

        // DIM=2 reference case, then back-to-back all-7s x all-2s.
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
        run(2, 1'b0, 1'b0, -1);
        chk("res_ref_00", pres[0][0], 64'd19);
        chk("res_ref_11", pres[1][1], 64'd50);
        for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) begin ma[r][c] = 7; mb[r][c] = 2; end
        run(2, 1'b0, 1'b0, -1);
        chk("res_b2b_01", pres[0][1], 64'd28);

        // DIM=4 identity times counting matrix.
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
            ma[r][c] = (r == c) ? 1 : 0;
            mb[r][c] = r*4 + c;
        end
        run(4, 1'b0, 1'b0, -1);
        chk("res_ident_32", pres[3][2], 64'd14);

        // start held high: one run, next accepted right after the first IDLE cycle.
        rand_mats(4, 1'b0);
        run(4, 1'b1, 1'b0, -1);
        rand_mats(4, 1'b1);
        run(4, 1'b0, 1'b0, -1);
        tick();
        check_step(4, 12);

        // Reset during FEED t=1, then a clean run.
        rand_mats(4, 1'b0);
        run(4, 1'b0, 1'b0, 2);
        tick();
        check_step(4, 12);
        rand_mats(4, 1'b0);
        run(4, 1'b0, 1'b0, -1);

        // Matrix inputs scrambled mid-run.
        rand_mats(2, 1'b1);
        run(2, 1'b0, 1'b1, -1);
        rand_mats(4, 1'b1);
        run(4, 1'b0, 1'b1, -1);

        for (int n = 0; n < 3; n++) begin
            rand_mats(4, n[0]);
            run(4, 1'b0, 1'b0, -1);
            rand_mats(2, n[0]);
            run(2, 1'b0, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_sched.md
# systolic_sched

Sequencing controller for a DIM×DIM systolic matrix-multiply array built from PE_unit tiles. It latches an A and a B operand matrix on start. It clears the PE accumulators, then drives the array's left and top edges with the diagonally skewed operand stream and zero-pads while the wavefront drains. It flags done on the cycle every PE res_o holds its final C[i][j].

## Interface
Parameters:
- DIM, 4: array dimension (rows = cols = inner dimension), ≥2
- DATA_W, 32: operand width; PE result width is 2*DATA_W

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  start request, sampled only in IDLE
- a_mat_i  in  DIM*DIM*DATA_W  A; element (r,c) at [(r*DIM+c)*DATA_W +: DATA_W]
- b_mat_i  in  DIM*DIM*DATA_W  B; same packing
- left_o  out  DIM*DATA_W  row i edge operand at [i*DATA_W +: DATA_W], to PE(i,0).left_i
- up_o  out  DIM*DATA_W  column j edge operand at [j*DATA_W +: DATA_W], to PE(0,j).up_i
- pe_clr_o  out  1  synchronous accumulator clear to all PEs
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse; all res_o valid this cycle

## Operation
- Array contract: each PE registers right_o/down_o (one hop = one cycle) and accumulates up_i*left_i into res_o on every edge; pe_clr_o zeroes res_o on the edge it is sampled.
- States: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- IDLE: edges 0, pe_clr_o 0. start_i=1 latches a_mat_i/b_mat_i into internal registers and moves to CLEAR. Later changes on the matrix inputs are ignored until the next start.
- CLEAR: one cycle, pe_clr_o=1, edges 0; t counter cleared to 0.
- FEED: t = 0..2*DIM-2. left_o row i = A[i][t-i] if 0 ≤ t-i < DIM, else 0. up_o column j = B[t-j][j] if 0 ≤ t-j < DIM, else 0.
- DRAIN: t = 2*DIM-1 .. 3*DIM-3; all edges 0. Zero operands add 0, so accumulators hold.
- DONE: t = 3*DIM-2; done_o=1 for one cycle, edges 0. Returns to IDLE next edge.
- start_i outside IDLE is ignored; there is no queueing.
- Arithmetic is none in this block: pure selection. The t counter is $clog2(3*DIM) bits and never wraps within a run.
- rst_i at any time, including mid-FEED: next state IDLE, all outputs 0, latched matrices 0. The PE array is reset by its own reset; a partial result is discarded.

## Timing
- Reset values: left_o=0, up_o=0, pe_clr_o=0, busy_o=0, done_o=0, state IDLE.
- All outputs are registered, with no combinational input-to-output path.
- Edge E0 samples start_i. CLEAR follows E0. FEED t=k follows E(1+k). done_o is high after E(3*DIM-1), which is 11 edges for DIM=4.
- busy_o is high from after E0 through the DONE cycle.
- A new start_i is accepted on the edge ending the first IDLE cycle after DONE. Minimum start-to-start spacing is 3*DIM+1 cycles.
- rst_i and start_i high together: reset wins.

## Structure
- Shared package systolic_pkg: state enum (IDLE, CLEAR, FEED, DRAIN, DONE), default DIM and DATA_W, index helper for (r,c) packing.
- Sub-module skew_feed (one instance per edge, for rows and for columns): given t, lane index and the latched matrix, it selects the element or 0. The FSM and t counter stay in systolic_sched.

## Test plan
- DIM=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse. Required response, checked at the edge ports:
  - left row0 = 1,2,0 at t=0,1,2; row1 = 0,3,4.
  - up col0 = 5,7,0; col1 = 0,6,8.
  - done_o after E5; with PE array attached, res = [[19,22],[43,50]].
- DIM=4, A=identity, B with B[r][c]=r*4+c → done after E11; res equals B; pe_clr_o high exactly one cycle, after E0.
- start_i held high through an entire run → exactly one run; done_o pulses once. A second run starts only from the IDLE cycle after DONE.
- rst_i asserted during FEED t=1 → next cycle all outputs 0 and busy_o=0. Next start gives full correct result with no stale operands.
- Back-to-back runs, second with A=all 7s and B=all 2s (DIM=2) → second result all 28s; proves CLEAR removes the first run's accumulation.
- a_mat_i changed mid-run → edge values still match the matrix latched at start.
